// File: rtl/fdsync_bank_pkg.sv
// fdsync_bank_pkg: select-width helpers shared by the staged register bank
package fdsync_bank_pkg;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/fdsync_chan.sv
// fdsync_chan: one channel's staging register, pending bit and active register
// FDSYNC_BANK_RDBK_EN exposes the staging register for readback
module fdsync_chan #(
    parameter int W = 16,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         immed,
    input  logic         wr_hit,
    input  logic [W-1:0] wdata,
    input  logic         commit,
`ifdef FDSYNC_BANK_RDBK_EN
    output logic [W-1:0] stg,
`endif
    output logic [W-1:0] q,
    output logic         pending,
    output logic         xfer
);
    logic [W-1:0] stg_r;
`ifdef FDSYNC_BANK_RDBK_EN
    assign stg = stg_r;
`endif
    // pending is never set on immediate channels, so it alone qualifies a transfer
    assign xfer = commit & pending;
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_r   <= RESET_VAL;
            q       <= RESET_VAL;
            pending <= 1'b0;
        end else if (immed) begin
            if (wr_hit) q <= wdata;
        end else begin
            if (xfer) q <= stg_r;
            if (wr_hit) begin
                stg_r   <= wdata;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/fdsync_bank.sv
// fdsync_bank: N-channel staged register bank, transferred to q on commit
// FDSYNC_BANK_RDBK_EN adds the rsel/rsrc/rdata readback mux
module fdsync_bank
    import fdsync_bank_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16,
    parameter logic [N-1:0] IMMED_MASK = '0,
    parameter logic [W-1:0] RESET_VAL = '0,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr,
    input  logic [SW-1:0]  wsel,
    input  logic [W-1:0]   wdata,
    input  logic           commit,
`ifdef FDSYNC_BANK_RDBK_EN
    input  logic [SW-1:0]  rsel,
    input  logic           rsrc,
    output logic [W-1:0]   rdata,
`endif
    output logic [N*W-1:0] q,
    output logic [N-1:0]   pending,
    output logic           committed
);
    logic [N-1:0] xfer;
`ifdef FDSYNC_BANK_RDBK_EN
    logic [W-1:0] stg_a [N];
    logic [W-1:0] act_a [N];
`endif
    for (genvar i = 0; i < N; i++) begin : g_chan
        fdsync_chan #(.W(W), .RESET_VAL(RESET_VAL)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .immed   (IMMED_MASK[i]),
            .wr_hit  (wr && (wsel == SW'(i))),
            .wdata   (wdata),
            .commit  (commit),
`ifdef FDSYNC_BANK_RDBK_EN
            .stg     (stg_a[i]),
`endif
            .q       (q[i*W +: W]),
            .pending (pending[i]),
            .xfer    (xfer[i])
        );
`ifdef FDSYNC_BANK_RDBK_EN
        assign act_a[i] = q[i*W +: W];
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) committed <= 1'b0;
        else committed <= |xfer;
    end
`ifdef FDSYNC_BANK_RDBK_EN
    // extra top bit so N == 2**SW still compares correctly
    always_comb begin
        rdata = '0;
        if ({1'b0, rsel} < (SW+1)'(N)) rdata = rsrc ? stg_a[rsel] : act_a[rsel];
    end
`endif
endmodule

// File: tb/tb_fdsync_bank.sv
// tb_fdsync_bank: scoreboard bench for fdsync_bank (N=4, W=16, ch2 immediate)
// FDSYNC_BANK_RDBK_EN enables the readback checks
module tb_fdsync_bank;
    logic        clk = 0;
    logic        reset = 0;
    logic        wr = 0;
    logic [1:0]  wsel = 0;
    logic [15:0] wdata = 0;
    logic        commit = 0;
    logic [63:0] q;
    logic [3:0]  pending;
    logic        committed;
`ifdef FDSYNC_BANK_RDBK_EN
    logic [1:0]  rsel = 0;
    logic        rsrc = 0;
    logic [15:0] rdata;
`endif
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] q;
        logic [3:0]  p;
        logic        c;
        string       name;
    } exp_t;
    exp_t sb [$];

    fdsync_bank #(.N(4), .W(16), .IMMED_MASK(4'b0100), .RESET_VAL(16'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .wsel      (wsel),
        .wdata     (wdata),
        .commit    (commit),
`ifdef FDSYNC_BANK_RDBK_EN
        .rsel      (rsel),
        .rsrc      (rsrc),
        .rdata     (rdata),
`endif
        .q         (q),
        .pending   (pending),
        .committed (committed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total += 3;
            if (q !== e.q) begin
                bad++;
                $display("FAIL %s q: got %h want %h", e.name, q, e.q);
            end
            if (pending !== e.p) begin
                bad++;
                $display("FAIL %s pending: got %b want %b", e.name, pending, e.p);
            end
            if (committed !== e.c) begin
                bad++;
                $display("FAIL %s committed: got %b want %b", e.name, committed, e.c);
            end
        end
    end

    task automatic step(input logic rs, input logic w, input logic [1:0] s,
                        input logic [15:0] d, input logic cm,
                        input logic [63:0] eq, input logic [3:0] ep,
                        input logic ec, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rs; wr = w; wsel = s; wdata = d; commit = cm;
        e.q = eq; e.p = ep; e.c = ec; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        step(1, 0, 0, 16'h0,    0, 64'h0, 4'b0000, 0, "reset");
        step(1, 1, 1, 16'h1234, 0, 64'h0, 4'b0000, 0, "reset_over_wr");
        step(0, 0, 0, 16'h0,    0, 64'h0, 4'b0000, 0, "idle");
        step(0, 1, 1, 16'h1234, 0, 64'h0, 4'b0010, 0, "stage1_a");
        step(0, 1, 1, 16'hBEEF, 0, 64'h0, 4'b0010, 0, "stage1_b");
        step(0, 0, 0, 16'h0,    1, 64'h0000_0000_BEEF_0000, 4'b0000, 1, "commit1");
        step(0, 0, 0, 16'h0,    0, 64'h0000_0000_BEEF_0000, 4'b0000, 0, "pulse_end");
        step(0, 1, 2, 16'h00AA, 0, 64'h0000_00AA_BEEF_0000, 4'b0000, 0, "immed2");
        step(0, 0, 0, 16'h0,    1, 64'h0000_00AA_BEEF_0000, 4'b0000, 0, "commit_none");
        step(0, 1, 0, 16'h1111, 0, 64'h0000_00AA_BEEF_0000, 4'b0001, 0, "stage0");
        step(0, 1, 0, 16'h2222, 1, 64'h0000_00AA_BEEF_1111, 4'b0001, 1, "wr_commit0");
        step(0, 0, 0, 16'h0,    1, 64'h0000_00AA_BEEF_2222, 4'b0000, 1, "commit0");
        step(0, 0, 0, 16'h0,    1, 64'h0000_00AA_BEEF_2222, 4'b0000, 0, "commit_idle");
        step(0, 1, 3, 16'h7777, 0, 64'h0000_00AA_BEEF_2222, 4'b1000, 0, "stage3");
        step(1, 0, 0, 16'h0,    0, 64'h0, 4'b0000, 0, "reset_mid");
        step(0, 0, 0, 16'h0,    1, 64'h0, 4'b0000, 0, "commit_after_rst");
        step(0, 1, 1, 16'h4444, 0, 64'h0, 4'b0010, 0, "stage1_c");
        step(0, 1, 2, 16'h0055, 1, 64'h0000_0055_4444_0000, 4'b0000, 1, "immed_commit");
        step(0, 1, 1, 16'h5A5A, 0, 64'h0000_0055_4444_0000, 4'b0010, 0, "stage1_d");
        step(0, 0, 0, 16'h0,    0, 64'h0000_0055_4444_0000, 4'b0010, 0, "hold");
`ifdef FDSYNC_BANK_RDBK_EN
        @(negedge clk);
        rsel = 1; rsrc = 1;
        #1;
        total++;
        if (rdata !== 16'h5A5A) begin
            bad++;
            $display("FAIL rd_stg: got %h want 5a5a", rdata);
        end
        rsrc = 0;
        #1;
        total++;
        if (rdata !== 16'h4444) begin
            bad++;
            $display("FAIL rd_act: got %h want 4444", rdata);
        end
`endif
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
